seg7_digit_scanner: RTL
=======================

Name: seg7_digit_scanner

Overview:
Downstream display stage for the seven-segment outputs of the user project. Accepts a packed multi-digit hex/BCD value over a valid/ready load port, holds it tear-free in a shadow register, and time-multiplexes the digits onto one shared 7-segment bus with one-hot digit enables. Inserts blanking gaps between digits to suppress ghosting. Drives the project IO pads and their output-enable bar.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8); digit 0 is least significant.
SCAN_DIV, 1024, clk cycles per digit slot (must be > BLANK_CYCLES).
BLANK_CYCLES, 16, cycles at the start of each slot with all digit enables off (0 = no blanking).

Ports:
clk  input  1  system clock (the only clock)
reset_n  input  1  asynchronous, active-low reset
digits_i  input  4*DIGITS  packed nibbles; [3:0] = digit 0
dp_i  input  DIGITS  decimal-point request per digit
load_valid  input  1  digits_i/dp_i valid
load_ready  output  1  block can accept a load
seg_out  output  7  segments, active-high, bit0=a .. bit6=g
dp_out  output  1  decimal point, active-high
digit_en  output  DIGITS  one-hot digit enable, active-high
frame_tick  output  1  one-cycle pulse at each frame boundary
io_oeb  output  8+DIGITS  pad output-enable bar for {digit_en, dp_out, seg_out}

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state and all outputs are registered.
- Reset values: seg_out=0, dp_out=0, digit_en=0, frame_tick=0, io_oeb=all ones, load_ready=1, active and pending registers=0, pending_full=0, digit index=0, slot counter=0, state=BLANK.
- io_oeb: all ones while reset_n is low; goes all zeros on the first clk edge after release and stays zero.
- Load handshake: transfer when load_valid && load_ready on a rising edge -> digits_i/dp_i captured into pending, pending_full set. load_ready = !pending_full (registered). Unaccepted data is ignored; no data loss.
- Frame boundary: the cycle the slot counter wraps while the digit index is DIGITS-1. On that edge: index->0, frame_tick=1 for one cycle; if pending_full then active<=pending, pending_full<=0 (load_ready rises the next cycle).
- Simultaneous load and boundary with pending empty: the load goes to pending only; it is copied at the NEXT boundary (no bypass).
- Load and boundary with pending full: the load is not accepted (ready low); the copy happens as normal.
- Latency: loaded data appears on the first ON phase of digit 0 in the frame after the next boundary.
- Slot FSM: BLANK (counter 0..BLANK_CYCLES-1): digit_en=0, seg_out=0, dp_out=0. ON (counter BLANK_CYCLES..SCAN_DIV-1): digit_en=1<<index, seg_out=decode(active nibble[index]), dp_out=active dp[index]. At counter=SCAN_DIV-1: counter->0, index->index+1 (wrapping DIGITS-1->0). With BLANK_CYCLES=0, BLANK is skipped.
- Decode (hex, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Counter width is $clog2(SCAN_DIV). Frame period is DIGITS*SCAN_DIV cycles exactly.
- Reset mid-frame returns all outputs and state immediately to the reset values above. Pending data is discarded.

Optional Feature:
SEG7_LZB_EN: when defined, leading-zero blanking is applied. Scanning from digit DIGITS-1 downward, each digit with nibble 0 and dp=0 is blanked (seg_out=0, dp_out=0, digit_en still asserted), stopping at the first nonzero nibble or set dp. Digit 0 is never blanked. Undefined: all digits are always shown.

Test Plan:
(Bench configuration: DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.)
- Reset release -> io_oeb=0xFFF until the first edge, then 0x000. digit_en is 0 for 2 cycles, then 0001 for 6 cycles, then 0000 for 2 cycles, then 0010. frame_tick pulses every 32 cycles.
- Load 0x1234, dp=0000 mid-frame -> load_ready low next cycle. From the next boundary, digit 0 shows 0x66 and digit 3 shows 0x06. load_ready high the cycle after the copy.
- Second load attempted while pending is full -> not accepted. The first value is displayed, then the second is accepted after ready rises.
- Load asserted exactly on a boundary cycle with pending empty -> the old value is shown for one more full frame, then 0xABCD (digit 3 shows 0x77).
- SEG7_LZB_EN defined, load 0x0070 -> digits 3 and 2 show seg 0x00, digit 1 shows 0x07, digit 0 shows 0x3F. Load 0x0000 with dp=0100 -> digit 2 shows 0x3F with dp_out=1.
- reset_n asserted mid-ON phase -> outputs and io_oeb take reset values asynchronously, the pending load is dropped, and the scan restarts at digit 0 in BLANK.

Source files
------------

// File: rtl/seg7_digit_scanner_if.sv
// Load port of the seven-segment digit scanner: packed nibbles and decimal
// points offered over a valid/ready handshake.
interface seg7_digit_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] digits_i;
  logic [DIGITS-1:0]   dp_i;
  logic                load_valid;
  logic                load_ready;

  modport master (
    output digits_i,
    output dp_i,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  digits_i,
    input  dp_i,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/seg7_digit_scanner.sv
// Multiplexed seven-segment scanner with tear-free shadow loading and blanking gaps.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_digit_scanner #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seg7_digit_scanner_if.slave   load,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_tick,
  output logic [8+DIGITS-1:0]   io_oeb
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } slot_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Registered state
  slot_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] active_dig_q, active_dig_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [4*DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_full_q, pend_full_d;
  logic                load_ready_q, load_ready_d;

  // Registered outputs
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                tick_q, tick_d;
  logic [8+DIGITS-1:0] oeb_q, oeb_d;

  // Combinational helpers
  logic                boundary;
  logic                accept;
  logic [DIGITS-1:0]   lzb_mask;
  logic                lead;
  logic [3:0]          cur_nib;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_dig_d = active_dig_q;
    active_dp_d  = active_dp_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_full_d  = pend_full_q;
    seg_d        = '0;
    dp_d         = 1'b0;
    en_d         = '0;
    oeb_d        = '0;
    lzb_mask     = '0;
    lead         = 1'b1;
    cur_nib      = '0;

    boundary = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    accept   = load.load_valid && load_ready_q;

    // Slot counter and digit index
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Shadow copy happens before the load is considered, so a load landing
    // on the boundary waits in pending for the following frame.
    if (boundary && pend_full_q) begin
      active_dig_d = pend_dig_q;
      active_dp_d  = pend_dp_q;
      pend_full_d  = 1'b0;
    end
    if (accept) begin
      pend_dig_d  = load.digits_i;
      pend_dp_d   = load.dp_i;
      pend_full_d = 1'b1;
    end
    load_ready_d = !pend_full_d;
    tick_d       = boundary;

    // Slot FSM: blanking gap at the start of each slot, then the lit phase.
    unique case (state_q)
      ST_BLANK: begin
        if ((BLANK_CYCLES == 0) || (cnt_d == CNT_ON)) state_d = ST_ON;
      end
      ST_ON: begin
        if ((cnt_q == CNT_LAST) && (BLANK_CYCLES != 0)) state_d = ST_BLANK;
      end
      default: state_d = ST_BLANK;
    endcase

`ifdef SEG7_LZB_EN
    // A digit is blanked while every digit above it (and itself) is a bare zero.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead        = lead && (active_dig_d[i*4 +: 4] == 4'h0) && !active_dp_d[i];
      lzb_mask[i] = lead;
    end
`else
    lzb_mask = '0;
`endif

    // Outputs are computed from next-cycle state so they line up with the counter.
    if (state_d == ST_ON) begin
      cur_nib = active_dig_d[int'(idx_d)*4 +: 4];
      en_d    = DIGITS'(1) << idx_d;
      if (!lzb_mask[idx_d]) begin
        seg_d = hex_to_seg(cur_nib);
        dp_d  = active_dp_d[idx_d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      en_q         <= '0;
      tick_q       <= 1'b0;
      oeb_q        <= '1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      load_ready_q <= load_ready_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      en_q         <= en_d;
      tick_q       <= tick_d;
      oeb_q        <= oeb_d;
    end
  end

  assign load.load_ready = load_ready_q;
  assign seg_out         = seg_q;
  assign dp_out          = dp_q;
  assign digit_en        = en_q;
  assign frame_tick      = tick_q;
  assign io_oeb          = oeb_q;

endmodule
